mbtrain_cal_tx: RTL and testbench
=================================

# mbtrain_cal_tx

Parametrised TX-side calibration handshake engine for MBTRAIN sub-states (SELFCAL and similar). On enable it runs a local calibration window of programmable length. It then issues a request message on the sideband and waits for the partner's response. Timeout and retry are optional. The block sits between the MBTRAIN sequencer (i_en / o_test_ack) and the sideband TX/RX mux.

## Interface
- MSG_W, 4: sideband message code width.
- CAL_CYCLES, 8: local calibration window in clk cycles; legal range 1..2^CNT_W-1.
- CNT_W, 8: calibration counter width.
- REQ_MSG, 4'b0001: request code driven after calibration.
- RSP_MSG, 4'b0010: response code that completes the handshake.
- TIMEOUT_CYCLES, 1024: response wait limit; used only with the timeout build.
- TO_W, 16: timeout counter width.
- MAX_RETRY, 2: request re-issues before error; used only with the timeout build.
- Reset is asynchronous, active-low: rst_n.
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- i_en  in  1  sub-state enable from MBTRAIN sequencer; low aborts or ends.
- i_sideband_valid  in  1  decoded sideband message valid.
- i_decoded_sideband_message  in  MSG_W  received message code.
- i_busy_negedge_detected  in  1  sideband TX finished current message.
- i_valid_rx  in  1  RX side currently owns the sideband mux.
- o_sideband_message  out  MSG_W  message code to sideband encoder.
- o_valid_tx  out  1  TX request to the sideband mux.
- o_test_ack  out  1  sub-state completed; held until i_en low.
- o_cal_busy  out  1  high while in CAL.
- o_error  out  1  handshake failed (timeout build); constant 0 otherwise.

## Operation
- States: IDLE, CAL, WAIT_RSP, DONE, ERROR. The encoding lives in the package.
- IDLE: on i_en=1, go to CAL and load the cal counter with CAL_CYCLES-1.
- CAL:
  - o_cal_busy=1; the counter decrements each cycle.
  - When the counter is 0, go to WAIT_RSP. On the same edge, o_sideband_message<=REQ_MSG and o_valid_tx<=1.
- WAIT_RSP:
  - A response is accepted only when i_sideband_valid=1 and i_decoded_sideband_message==RSP_MSG. Every other code or valid pulse is ignored.
  - On accept: go to DONE, o_sideband_message<=0, o_test_ack<=1.
- DONE: hold o_test_ack=1. On i_en=0, go to IDLE.
- ERROR (timeout build only): o_error=1 and o_valid_tx=0. On i_en=0, go to IDLE.
- Abort: i_en=0 in any state sends the FSM to IDLE on the next edge. In IDLE, all outputs register to 0.
- o_valid_tx rule:
  - Set on entry to WAIT_RSP and on each retry.
  - Otherwise cleared when i_busy_negedge_detected=1 and i_valid_rx=0.
  - Set has priority over clear.
  - o_valid_tx is not cleared by response acceptance.
- Timeout (build option):
  - The timer counts WAIT_RSP cycles and reaches TIMEOUT_CYCLES with no accepted response.
  - If retry count < MAX_RETRY: re-issue REQ_MSG (o_valid_tx<=1), increment retry count, clear the timer.
  - Otherwise go to ERROR.
- Simultaneous response and timeout: the response wins and the FSM goes to DONE.
- Illegal state: go to IDLE.

## Timing
- All outputs are registered. Reset values: o_sideband_message=0, o_valid_tx=0, o_test_ack=0, o_cal_busy=0, o_error=0.
- i_en rising at edge N puts the FSM in CAL from N+1. REQ_MSG and o_valid_tx appear at edge N+1+CAL_CYCLES.
- An accepted response at edge M gives o_test_ack=1 from M+1.
- Asserting rst_n low mid-operation returns the FSM to IDLE immediately. All counters clear.

## Configuration
- SELFCAL_TIMEOUT_EN defined:
  - The timeout counter, retry counter and ERROR state are compiled in.
  - o_error is live.
- SELFCAL_TIMEOUT_EN undefined:
  - WAIT_RSP waits indefinitely.
  - No timer or retry logic exists.
  - o_error is tied 0.
  - TIMEOUT_CYCLES, TO_W and MAX_RETRY are unused.

## Structure
- Shared package mbtrain_pkg holds:
  - the state encoding;
  - default message codes (SELFCAL_REQ=4'b0001, SELFCAL_RSP=4'b0010);
  - the MSG_W default.
- Sub-module sb_valid_ctrl holds the o_valid_tx set/clear register (inputs: set, busy_negedge, valid_rx, abort). It is reusable by the other MBTRAIN TX blocks.

## Test plan
- CAL_CYCLES=8, i_en rises at cycle 0 -> o_cal_busy high for cycles 1..8; REQ_MSG=0001 and o_valid_tx=1 at cycle 9.
- Drive RSP_MSG=0010 with valid 5 cycles after the request -> o_test_ack=1 the next cycle, o_sideband_message=0. Drop i_en -> all outputs 0 one cycle later.
- Drive code 0011 with valid, then 0010 without valid -> no transition, remains in WAIT_RSP.
- With o_valid_tx=1, pulse busy_negedge while i_valid_rx=1 -> valid stays 1. Pulse it while i_valid_rx=0 -> valid 0 next cycle.
- Timeout build, TIMEOUT_CYCLES=16, MAX_RETRY=2, no response:
  - o_valid_tx re-asserts at waits 16 and 32;
  - o_error=1 after the third expiry;
  - response arriving on the same cycle as an expiry -> o_test_ack=1, o_error=0.
- Assert rst_n low mid-CAL and again mid-WAIT_RSP -> all outputs 0 and the FSM in IDLE. After release with i_en held high, the full sequence restarts from CAL.

Source files
------------

// File: rtl/mbtrain_pkg.sv
// Shared MBTRAIN definitions: FSM state encoding, default sideband message codes and width.
package mbtrain_pkg;

    localparam int MSG_W_DEFAULT = 4;

    localparam logic [MSG_W_DEFAULT-1:0] SELFCAL_REQ = 4'b0001;
    localparam logic [MSG_W_DEFAULT-1:0] SELFCAL_RSP = 4'b0010;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAL      = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERROR    = 3'd4
    } cal_state_e;

endpackage

// File: rtl/sb_valid_ctrl.sv
// Sideband TX valid register: set by a new request, cleared once the sideband TX
// finishes a message while RX does not own the mux; abort clears unconditionally.
module sb_valid_ctrl (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic busy_negedge,
    input  logic valid_rx,
    input  logic abort,
    output logic valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (abort) begin
            valid <= 1'b0;
        end else if (set) begin
            valid <= 1'b1;
        end else if (busy_negedge && !valid_rx) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mbtrain_cal_tx.sv
// MBTRAIN TX calibration handshake: local cal window, then REQ on sideband and wait for RSP.
// Build option SELFCAL_TIMEOUT_EN adds the response timeout, request retries and ERROR state.
module mbtrain_cal_tx
    import mbtrain_pkg::*;
#(
    parameter int                 MSG_W          = MSG_W_DEFAULT,
    parameter int                 CAL_CYCLES     = 8,
    parameter int                 CNT_W          = 8,
    parameter logic [MSG_W-1:0]   REQ_MSG        = MSG_W'(SELFCAL_REQ),
    parameter logic [MSG_W-1:0]   RSP_MSG        = MSG_W'(SELFCAL_RSP),
    parameter int                 TIMEOUT_CYCLES = 1024,
    parameter int                 TO_W           = 16,
    parameter int                 MAX_RETRY      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_sideband_valid,
    input  logic [MSG_W-1:0] i_decoded_sideband_message,
    input  logic             i_busy_negedge_detected,
    input  logic             i_valid_rx,
    output logic [MSG_W-1:0] o_sideband_message,
    output logic             o_valid_tx,
    output logic             o_test_ack,
    output logic             o_cal_busy,
    output logic             o_error
);

    cal_state_e       state_q, state_d;
    logic [CNT_W-1:0] cal_cnt_q;
    logic             accept;
    logic             issue_req;

    assign accept = i_sideband_valid && (i_decoded_sideband_message == RSP_MSG);

`ifdef SELFCAL_TIMEOUT_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic [RW-1:0]   retry_q;
    logic            expire;

    // A response on the expiry cycle wins, so expiry is masked by accept.
    assign expire = (state_q == ST_WAIT_RSP) && !accept
                    && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d   = state_q;
        issue_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_en) state_d = ST_CAL;
            end
            ST_CAL: begin
                if (cal_cnt_q == '0) begin
                    state_d   = ST_WAIT_RSP;
                    issue_req = 1'b1;
                end
            end
            ST_WAIT_RSP: begin
                if (accept) begin
                    state_d = ST_DONE;
                end
`ifdef SELFCAL_TIMEOUT_EN
                else if (expire) begin
                    if (retry_q < RW'(MAX_RETRY)) issue_req = 1'b1;
                    else                          state_d   = ST_ERROR;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
`ifdef SELFCAL_TIMEOUT_EN
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!i_en) begin
            state_d   = ST_IDLE;
            issue_req = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cal_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && state_d == ST_CAL) begin
                cal_cnt_q <= CNT_W'(CAL_CYCLES - 1);
            end else if (state_q == ST_CAL && cal_cnt_q != '0) begin
                cal_cnt_q <= cal_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sideband_message <= '0;
            o_test_ack         <= 1'b0;
            o_cal_busy         <= 1'b0;
        end else begin
            if (state_d == ST_IDLE || state_d == ST_ERROR) begin
                o_sideband_message <= '0;
            end else if (issue_req) begin
                o_sideband_message <= REQ_MSG;
            end else if (state_q == ST_WAIT_RSP && state_d == ST_DONE) begin
                o_sideband_message <= '0;
            end
            o_test_ack <= (state_d == ST_DONE);
            o_cal_busy <= (state_d == ST_CAL);
        end
    end

`ifdef SELFCAL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            retry_q  <= '0;
            o_error  <= 1'b0;
        end else begin
            if (state_d != ST_WAIT_RSP || issue_req) to_cnt_q <= '0;
            else                                     to_cnt_q <= to_cnt_q + 1'b1;
            if (state_q != ST_WAIT_RSP)       retry_q <= '0;
            else if (issue_req)               retry_q <= retry_q + 1'b1;
            o_error <= (state_d == ST_ERROR);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES + TO_W + MAX_RETRY) != 0;
    assign o_error    = 1'b0;
`endif

    // ERROR shares the abort path so o_valid_tx drops on entry to ERROR.
    sb_valid_ctrl u_valid_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .set          (issue_req),
        .busy_negedge (i_busy_negedge_detected),
        .valid_rx     (i_valid_rx),
        .abort        (state_d == ST_IDLE || state_d == ST_ERROR),
        .valid        (o_valid_tx)
    );

endmodule

// File: tb/tb_mbtrain_cal_tx.sv
// Randomized self-checking bench for mbtrain_cal_tx against a cycle-level behavioural model.
module tb_mbtrain_cal_tx;

    localparam int         MSG_W    = 4;
    localparam int         CAL_CYC  = 8;
    localparam int         TO_CYC   = 16;
    localparam int         MAX_RTY  = 2;
    localparam logic [3:0] REQ      = 4'b0001;
    localparam logic [3:0] RSP      = 4'b0010;

    localparam int PH_OFF = 0, PH_CAL = 1, PH_WAIT = 2, PH_DONE = 3, PH_FAIL = 4;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             sv;
    logic [MSG_W-1:0] code;
    logic             bn;
    logic             vrx;
    logic [MSG_W-1:0] msg;
    logic             vld;
    logic             ack;
    logic             busy;
    logic             err;

    mbtrain_cal_tx #(
        .MSG_W          (MSG_W),
        .CAL_CYCLES     (CAL_CYC),
        .CNT_W          (8),
        .REQ_MSG        (REQ),
        .RSP_MSG        (RSP),
        .TIMEOUT_CYCLES (TO_CYC),
        .TO_W           (16),
        .MAX_RETRY      (MAX_RTY)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .i_en                       (en),
        .i_sideband_valid           (sv),
        .i_decoded_sideband_message (code),
        .i_busy_negedge_detected    (bn),
        .i_valid_rx                 (vrx),
        .o_sideband_message         (msg),
        .o_valid_tx                 (vld),
        .o_test_ack                 (ack),
        .o_cal_busy                 (busy),
        .o_error                    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural reference: phase, elapsed cycles and the expected outputs.
    int         m_ph;
    int         m_cal_n;
    int         m_waited;
    int         m_retries;
    logic [3:0] e_msg;
    logic       e_vld, e_ack, e_busy, e_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = PH_OFF; m_cal_n = 0; m_waited = 0; m_retries = 0;
        e_msg = '0; e_vld = 0; e_ack = 0; e_busy = 0; e_err = 0;
    endtask

    task automatic model_edge();
        bit set_v;
        set_v = 0;
        if (!en) begin
            model_reset();
        end else begin
            case (m_ph)
                PH_OFF: begin
                    m_ph = PH_CAL; m_cal_n = 0;
                end
                PH_CAL: begin
                    m_cal_n++;
                    if (m_cal_n == CAL_CYC) begin
                        m_ph = PH_WAIT; e_msg = REQ; set_v = 1;
                        m_waited = 0; m_retries = 0;
                    end
                end
                PH_WAIT: begin
                    if (sv && code == RSP) begin
                        m_ph = PH_DONE; e_msg = '0; e_ack = 1;
                    end else begin
                        m_waited++;
`ifdef SELFCAL_TIMEOUT_EN
                        if (m_waited == TO_CYC) begin
                            if (m_retries < MAX_RTY) begin
                                m_retries++; m_waited = 0; set_v = 1;
                            end else begin
                                m_ph = PH_FAIL; e_err = 1; e_msg = '0;
                            end
                        end
`endif
                    end
                end
                default: ;
            endcase
            if (set_v)                e_vld = 1;
            else if (bn && !vrx)      e_vld = 0;
            if (m_ph == PH_FAIL)      e_vld = 0;
        end
        e_busy = (m_ph == PH_CAL);
    endtask

    task automatic check_all();
        chk("msg",   32'(msg),  32'(e_msg));
        chk("valid", 32'(vld),  32'(e_vld));
        chk("ack",   32'(ack),  32'(e_ack));
        chk("busy",  32'(busy), 32'(e_busy));
        chk("error", 32'(err),  32'(e_err));
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic quiet();
        sv = 0; code = '0; bn = 0; vrx = 0;
    endtask

    task automatic async_reset();
        rst_n = 0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        tick();
        rst_n = 1;
    endtask

    initial begin
        int target;
        rst_n = 0; en = 0;
        quiet();
        model_reset();
        repeat (2) tick();
        rst_n = 1;
        repeat (2) tick();

        // Nominal handshake with ignored traffic and valid clear rules.
        en = 1;
        repeat (CAL_CYC + 6) tick();
        sv = 1; code = 4'b0011; tick();
        sv = 0; code = RSP;     tick();
        sv = 1; code = RSP;     tick();
        quiet();                tick();
        bn = 1; vrx = 1;        tick();
        bn = 1; vrx = 0;        tick();
        quiet(); en = 0;
        repeat (2) tick();

        // Long silence: retries and error in the timeout build.
        en = 1;
        repeat (CAL_CYC + 3 * TO_CYC + 10) tick();
        en = 0;
        repeat (2) tick();

        // Response lands on the final expiry cycle.
`ifdef SELFCAL_TIMEOUT_EN
        target = MAX_RTY;
`else
        target = 0;
`endif
        en = 1;
        for (int i = 0; i < 200 && m_ph != PH_DONE; i++) begin
            if (m_ph == PH_WAIT && m_waited == TO_CYC - 1 && m_retries == target) begin
                sv = 1; code = RSP;
            end else begin
                sv = 0; code = '0;
            end
            tick();
        end
        chk("simul_ack", 32'(ack), 32'd1);
        quiet(); en = 0;
        repeat (2) tick();

        // Reset mid-CAL and mid-WAIT_RSP with enable held high.
        en = 1;
        repeat (3) tick();
        async_reset();
        repeat (CAL_CYC + 4) tick();
        async_reset();
        repeat (CAL_CYC + 4) tick();
        en = 0;
        repeat (2) tick();

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            if (!en) en = ($urandom % 4) == 0;
            else     en = ($urandom % 60) != 0;
            sv   = ($urandom % 6) == 0;
            code = 4'($urandom % 4);
            bn   = ($urandom % 3) == 0;
            vrx  = 1'($urandom % 2);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
